// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl_if                                             |
// | Description : Signal bundle between the MIPS datapath and the hazard /   |
// |               redirect controller.                                       |
// |   slave  : controller side (takes hazard info, drives pipeline ctrls)    |
// |   master : datapath side (drives hazard info, takes pipeline ctrls)      |
// |   Hazard info : ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,   |
// |                 jump_ex, branch_taken, stall_ext                         |
// |   Controls    : pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble,   |
// |                 exmem_flush, stalling, stall_count, flush_count          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             jump_ex;
  logic             branch_taken;
  logic             stall_ext;

  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_flush;
  logic             stalling;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           jump_ex, branch_taken, stall_ext,
    output pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble,
           exmem_flush, stalling, stall_count, flush_count
  );

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           jump_ex, branch_taken, stall_ext,
    input  pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble,
           exmem_flush, stalling, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : Hazard and redirect controller for the five-stage MIPS     |
// |               pipeline. Inserts load-use bubbles, flushes younger        |
// |               stages on jumps (EX) and taken branches (MEM), freezes the |
// |               front end on external stalls, and keeps saturating stall / |
// |               flush performance counters.                                |
// |   clk   : rising-edge clock                                              |
// |   rst_n : asynchronous active-low reset                                  |
// |   bus   : hazard_ctrl_if.slave (hazard info in, pipeline controls out)   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [1:0]       c_SEL_PC4    = 2'b00;
  localparam logic [1:0]       c_SEL_JUMP   = 2'b01;
  localparam logic [1:0]       c_SEL_BRANCH = 2'b10;
  // The hazard cycle itself is the first bubble; STALL covers the rest.
  localparam logic [2:0]       c_REM_INIT   = 3'(STALL_CYCLES - 1);
  localparam bit               c_MULTI      = (STALL_CYCLES > 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_rem;
  logic [2:0]       w_next_rem;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic             w_luh;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic [1:0]       w_pc_sel;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_exmem_flush;

  // $zero is never a real dependency; rt only matters when ID reads it.
  assign w_luh = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                 ((bus.idex_rt == bus.ifid_rs) ||
                  (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

  always_comb begin
    w_next_state  = r_state;
    w_next_rem    = r_rem;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_pc_sel      = c_SEL_PC4;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_flush = 1'b0;

    if (!rst_n) begin
      // Hold the pipeline frozen with a bubble while reset is asserted.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      w_pc_sel      = c_SEL_BRANCH;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_exmem_flush = 1'b1;
      w_next_state  = ST_RUN;
      w_next_rem    = 3'd0;
    end else if (bus.jump_ex) begin
      // Jump resolves in EX, so EX/MEM holds the jump itself and survives.
      w_pc_sel      = c_SEL_JUMP;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_next_state  = ST_RUN;
      w_next_rem    = 3'd0;
    end else if (bus.stall_ext) begin
      // State and rem hold: the load-use countdown pauses.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
    end else if (r_state == ST_STALL) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_next_rem    = r_rem - 3'd1;
      if (r_rem == 3'd1) begin
        w_next_state = ST_RUN;
      end
    end else if (w_luh) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      if (c_MULTI) begin
        w_next_state = ST_STALL;
        w_next_rem   = c_REM_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_rem         <= 3'd0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
      if (!w_pc_write && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + c_CNT_ONE;
      end
      if (w_ifid_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + c_CNT_ONE;
      end
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.stalling    = (r_state == ST_STALL);
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and redirect controller for the five-stage MIPS datapath. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It detects load-use hazards and inserts bubbles into ID/EX, and it flushes younger stages on jumps (resolved in EX) and taken branches (resolved in MEM). It also freezes the front end on an external stall and keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..7)
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs  in  5  rs field of the instruction in ID
- ifid_rt  in  5  rt field of the instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt (R-type, store, branch)
- idex_memread  in  1  instruction in EX is a load
- idex_rt  in  5  destination register of the load in EX
- jump_ex  in  1  jump in EX (registered jump bit from ID/EX)
- branch_taken  in  1  branch in MEM resolved taken
- stall_ext  in  1  external front-end stall request (e.g. memory not ready)
- pc_write  out  1  PC load enable
- pc_sel  out  2  00 PC+4, 01 jump target, 10 branch target
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_bubble  out  1  zero WB/M/EX control fields entering ID/EX
- exmem_flush  out  1  zero control fields entering EX/MEM
- stalling  out  1  FSM in STALL state
- stall_count  out  CNT_W  cycles with pc_write=0 (saturating)
- flush_count  out  CNT_W  cycles with ifid_flush=1 (saturating)

## Operation
- FSM states are RUN and STALL, with a down-counter rem (3 bits).
- Load-use hazard (luh) = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
- Outputs are Mealy and combinational from state and inputs. They are evaluated in fixed priority order:
  1. branch_taken: pc_write=1, pc_sel=10, ifid_flush=1, idex_bubble=1, exmem_flush=1. Next state is RUN and rem is cleared, aborting any STALL.
  2. jump_ex: pc_write=1, pc_sel=01, ifid_flush=1, idex_bubble=1, exmem_flush=0. Next state is RUN, aborting any STALL.
  3. stall_ext: pc_write=0, ifid_write=0, idex_bubble=1. State and rem hold, so the countdown pauses.
  4. STALL: pc_write=0, ifid_write=0, idex_bubble=1. rem decrements; when rem==1, next state is RUN.
  5. RUN with luh: same outputs as STALL. If STALL_CYCLES>1, next state is STALL with rem=STALL_CYCLES-1; otherwise the FSM stays in RUN.
  6. Otherwise: pc_write=1, ifid_write=1, pc_sel=00, all flush/bubble signals 0.
- Any output not listed in a case takes its default: pc_write=1, ifid_write=1, pc_sel=00, flush/bubble signals 0.
- luh is ignored while in STALL. The bubble already sits in EX.
- stall_count increments on every edge where pc_write=0, and flush_count on every edge where ifid_flush=1. Both saturate at all-ones.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, rem=0, counters=0.
- While rst_n is low, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, exmem_flush=0, pc_sel=00, stalling=0.
- After reset deasserts, the first rising edge behaves per the Operation rules.
- Hazard-to-response latency is 0 cycles: controls are valid in the same cycle as the inputs and act at the next rising edge.
- A load-use hazard costs exactly STALL_CYCLES cycles of pc_write=0, absent higher-priority events.
- stalling is registered state. It rises the cycle after luh when STALL_CYCLES>1 and falls on the edge where rem==1 or on an abort.
- Simultaneous events:
  - branch_taken with jump_ex: branch wins (pc_sel=10).
  - Either redirect with stall_ext: the redirect wins.
  - luh with jump_ex: the jump wins, no stall is started, and the ID instruction is flushed.
- Reset mid-STALL returns immediately to RUN with rem=0.

## Test plan
- Load-use, STALL_CYCLES=1: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_count=1; stalling stays 0.
- Load-use, STALL_CYCLES=3: same stimulus, then inputs cleared -> pc_write=0 for exactly 3 cycles; stalling high for cycles 2-3; stall_count=3.
- No hazard on $zero or unused rt: idex_rt=0 matching ifid_rs, then idex_rt=9, ifid_rt=9, ifid_uses_rt=0 -> pc_write=1 and idex_bubble=0 throughout.
- Abort: STALL_CYCLES=3, luh, then branch_taken on cycle 2 -> pc_sel=10 with all three flushes; stalling=0 next cycle; flush_count=1; stall_count=1.
- Priority: branch_taken=1, jump_ex=1, stall_ext=1 together -> pc_sel=10, pc_write=1. Then stall_ext alone during STALL -> rem holds, and the stall length is extended by the stall_ext duration.
- Reset and saturation: CNT_W=4, hold stall_ext for 20 cycles -> stall_count=15. Pull rst_n low mid-STALL -> counters=0 and outputs at reset values asynchronously, before the next clock edge.
